// File: rtl/pe_column_collector_pkg.sv
// Shared types for the systolic-array column collector: PE result beat,
// PE command encoding and the per-bank fill state.
package pe_column_collector_pkg;

  localparam int FLOAT_SIZE      = 32;
  localparam int COLLECTOR_SLOTS = 4;

  typedef enum logic [1:0] {
    PE_COMMAND_IDLE     = 2'd0,
    PE_COMMAND_NORMAL   = 2'd1,
    PE_COMMAND_FLUSH    = 2'd2,
    PE_COMMAND_RESERVED = 2'd3
  } PE_Command;

  typedef struct packed {
    logic [FLOAT_SIZE-1:0] data;
    PE_Command             command;
    logic                  phase;
    logic [1:0]            id;
  } PE_C_Result;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } CollectorBankState;

  function automatic logic lane_valid(input PE_C_Result r);
    return (r.command == PE_COMMAND_NORMAL);
  endfunction

endpackage

// File: rtl/pe_column_collector_bank.sv
// One phase bank of the collector: four result slots with valid bits, two
// write ports (port 0 wins on a same-slot conflict) and a drain clear.
module pe_column_collector_bank
  import pe_column_collector_pkg::*;
#(
  parameter int FLOAT_SIZE = pe_column_collector_pkg::FLOAT_SIZE
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr0_en_i,
  input  logic [1:0]                            wr0_id_i,
  input  logic [FLOAT_SIZE-1:0]                 wr0_data_i,
  input  logic                                  wr1_en_i,
  input  logic [1:0]                            wr1_id_i,
  input  logic [FLOAT_SIZE-1:0]                 wr1_data_i,
  input  logic                                  clear_i,
  output logic                                  full_o,
  output logic [COLLECTOR_SLOTS*FLOAT_SIZE-1:0] data_o,
  output logic                                  overflow_o,
  output logic                                  collision_o
);

  CollectorBankState                               state_q, state_d;
  logic [COLLECTOR_SLOTS-1:0]                      valid_q, valid_d;
  logic [COLLECTOR_SLOTS-1:0][FLOAT_SIZE-1:0]      slot_q, slot_d;

  assign full_o = (state_q == BANK_FULL);
  assign data_o = slot_q;

  // A full bank ignores writes (even in its drain cycle); otherwise lane 1 is applied first so lane 0 overrides it.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    slot_d      = slot_q;
    overflow_o  = 1'b0;
    collision_o = 1'b0;
    case (state_q)
      BANK_FULL: begin
        if (clear_i) begin
          valid_d = '0;
          state_d = BANK_EMPTY;
        end else begin
          state_d = BANK_FULL;
        end
        overflow_o = wr0_en_i | wr1_en_i;
      end
      BANK_EMPTY, BANK_FILLING: begin
        if (wr1_en_i) begin
          collision_o        = valid_q[wr1_id_i];
          slot_d[wr1_id_i]   = wr1_data_i;
          valid_d[wr1_id_i]  = 1'b1;
        end else begin
          collision_o = 1'b0;
        end
        if (wr0_en_i) begin
          collision_o       = collision_o | valid_q[wr0_id_i] | (wr1_en_i && (wr1_id_i == wr0_id_i));
          slot_d[wr0_id_i]  = wr0_data_i;
          valid_d[wr0_id_i] = 1'b1;
        end else begin
          valid_d = valid_d;
        end
        if (&valid_d) begin
          state_d = BANK_FULL;
        end else if (|valid_d) begin
          state_d = BANK_FILLING;
        end else begin
          state_d = BANK_EMPTY;
        end
      end
      default: begin
        valid_d = '0;
        state_d = BANK_EMPTY;
      end
    endcase
  end

  // Bank state and valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Slot payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/pe_column_collector_chk.sv
// Protocol checker: the presented group must not change while stalled.
module pe_column_collector_chk #(
  parameter int FLOAT_SIZE = 32,
  parameter int ID_H       = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic                    m_valid,
  input logic                    m_ready,
  input logic [4*FLOAT_SIZE-1:0] m_data,
  input logic                    m_phase
);

  logic                    stall_q;
  logic [4*FLOAT_SIZE-1:0] data_q;
  logic                    phase_q;

  // Compare this cycle's output against the one stalled last cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        assert (m_valid && (m_data == data_q) && (m_phase == phase_q))
          else $error("column %0d: output changed under backpressure", ID_H);
      end else begin
        stall_q <= stall_q;
      end
      stall_q <= m_valid && !m_ready;
    end
    data_q  <= m_data;
    phase_q <= m_phase;
  end

endmodule

// File: rtl/pe_column_collector.sv
// Bottom-of-column collector: gathers four PE results per phase bank and
// hands complete groups downstream, draining the banks in strict alternation.
module pe_column_collector
  import pe_column_collector_pkg::*;
#(
  parameter int FLOAT_SIZE = pe_column_collector_pkg::FLOAT_SIZE,
  parameter int ID_H       = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  PE_C_Result                            Cside_in0,
  input  PE_C_Result                            Cside_in1,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [COLLECTOR_SLOTS*FLOAT_SIZE-1:0] m_data,
  output logic                                  m_phase,
  output logic [15:0]                           group_count,
  output logic                                  overflow_err,
  output logic                                  collision_err
);

  logic                                  rd_bank_q, rd_bank_d;
  logic [15:0]                           group_count_q, group_count_d;
  logic                                  overflow_q, overflow_d;
  logic                                  collision_q, collision_d;
  logic [1:0]                            bank_full_s;
  logic [1:0]                            bank_ovf_s;
  logic [1:0]                            bank_col_s;
  logic [1:0]                            bank_clear_s;
  logic [1:0][COLLECTOR_SLOTS*FLOAT_SIZE-1:0] bank_data_s;
  logic                                  handshake_s;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pe_column_collector_bank #(.FLOAT_SIZE(FLOAT_SIZE)) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr0_en_i    (lane_valid(Cside_in0) && (Cside_in0.phase == 1'(b))),
      .wr0_id_i    (Cside_in0.id),
      .wr0_data_i  (Cside_in0.data),
      .wr1_en_i    (lane_valid(Cside_in1) && (Cside_in1.phase == 1'(b))),
      .wr1_id_i    (Cside_in1.id),
      .wr1_data_i  (Cside_in1.data),
      .clear_i     (bank_clear_s[b]),
      .full_o      (bank_full_s[b]),
      .data_o      (bank_data_s[b]),
      .overflow_o  (bank_ovf_s[b]),
      .collision_o (bank_col_s[b])
    );
  end

  assign m_valid       = bank_full_s[rd_bank_q];
  assign m_data        = m_valid ? bank_data_s[rd_bank_q] : '0;
  assign m_phase       = rd_bank_q;
  assign group_count   = group_count_q;
  assign overflow_err  = overflow_q;
  assign collision_err = collision_q;
  assign handshake_s   = m_valid && m_ready;
  assign bank_clear_s  = {handshake_s && rd_bank_q, handshake_s && !rd_bank_q};

  // Read pointer, accepted-group counter and sticky error flags.
  always_comb begin
    rd_bank_d     = rd_bank_q;
    group_count_d = group_count_q;
    if (handshake_s) begin
      rd_bank_d     = ~rd_bank_q;
      group_count_d = group_count_q + 16'd1;
    end else begin
      group_count_d = group_count_q;
    end
    overflow_d  = overflow_q | (|bank_ovf_s);
    collision_d = collision_q | (|bank_col_s);
  end

  // Top-level control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q     <= 1'b0;
      group_count_q <= 16'd0;
      overflow_q    <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      rd_bank_q     <= rd_bank_d;
      group_count_q <= group_count_d;
      overflow_q    <= overflow_d;
      collision_q   <= collision_d;
    end
  end

  pe_column_collector_chk #(.FLOAT_SIZE(FLOAT_SIZE), .ID_H(ID_H)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_phase (m_phase)
  );

endmodule

// File: doc/pe_column_collector.md
# pe_column_collector

Bottom-of-column result collector for the systolic array. It consumes the two C-side result lanes leaving the last PE of a column: lane 0 carries the primary id and lane 1 the skip id. Each result is written into a 4-slot group selected by its phase bit. When a group has all four slots written, it is presented downstream as one 4-float vector over a valid/ready handshake. Two phase banks allow one group to fill while the other drains.

## Interface
Parameters:
- FLOAT_SIZE, default SPARQ_PKG::FLOAT_SIZE, width of one result word.
- ID_H, default 0, column index; used only for assertion messages.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- Cside_in0  in  PE_C_Result  lane 0: data, command, phase, id.
- Cside_in1  in  PE_C_Result  lane 1: data, command, phase, id (skip id).
- m_valid  out  1  the output group is valid.
- m_ready  in  1  downstream accepts the group.
- m_data  out  4*FLOAT_SIZE  slot k occupies bits [k*FLOAT_SIZE +: FLOAT_SIZE].
- m_phase  out  1  bank index of the presented group.
- group_count  out  16  number of groups accepted downstream; wraps modulo 2^16.
- overflow_err  out  1  sticky; a write targeted a FULL bank.
- collision_err  out  1  sticky; a slot was written twice before its group drained.

## Operation
- A lane beat is valid when its command equals PE_COMMAND_NORMAL. Any other command is ignored.
- Each valid beat writes its data into slot `id` of bank `phase`, and sets that slot's valid bit.
- Bank states:
  - EMPTY: no slot valid. The first write moves the bank to FILLING.
  - FILLING: some slots valid. When all 4 valid bits are set after a cycle's writes, the bank moves to FULL.
  - FULL: holds a complete group. A handshake while the bank is selected for output clears all valid bits and moves it to EMPTY.
- Output bank selection:
  - The read pointer rd_bank starts at 0.
  - m_valid = (bank[rd_bank] is FULL).
  - On handshake (m_valid && m_ready), rd_bank toggles and group_count increments.
  - Banks therefore drain strictly in alternating order, even when the other bank completes first.
- Boundary rules:
  - Write to a FULL bank: the data is dropped, the bank is unchanged, overflow_err is set. This includes a write to the bank being drained in the same handshake cycle.
  - Write to an already-valid slot of a FILLING bank: the data is overwritten and collision_err is set.
  - Both lanes valid with the same phase and the same id in one cycle: lane 0 data is kept and collision_err is set.
  - Both lanes in one cycle with different phases: each write goes to its own bank independently.
  - Writes to the non-draining bank in a handshake cycle proceed normally.
- Reset (rst_n = 0 at posedge):
  - Both banks go to EMPTY and all valid bits clear.
  - rd_bank = 0, group_count = 0, both error flags = 0.
  - Slot data need not be cleared.
  - Reset mid-operation discards all partial and full groups.

## Timing
- Output reset values: m_valid 0, m_data 0, m_phase 0, group_count 0, overflow_err 0, collision_err 0.
- m_data is driven from the bank registers, and is forced to 0 while m_valid = 0.
- Latency: if the write completing a group lands at posedge t and that bank is rd_bank, then m_valid = 1 after posedge t, i.e. the write-to-valid latency is 1 cycle.
- m_valid, m_data and m_phase are held stable while m_valid && !m_ready.
- Throughput: one group per cycle is possible when both banks are FULL and m_ready is held high.
- Error flags rise after the posedge of the offending write and stay high until reset.

## Structure
- In SPARQ_PKG:
  - Add enum CollectorBankState {BANK_EMPTY, BANK_FILLING, BANK_FULL}.
  - Add localparam COLLECTOR_SLOTS = 4.
  - Reuse PE_C_Result and PE_COMMAND_NORMAL.
- Sub-module collector_bank, instantiated twice. It holds the state, 4 slot registers and 4 valid bits. It takes two write ports (lane 0 has priority), a clear input and a full output, and reports its overflow and collision events.
- The top level holds rd_bank, group_count, the error flags and the output muxing.

## Test plan
- Basic group: lane0 (phase 0, id 0, data 0x3F800000) plus lane1 (phase 0, id 2, 0x40000000), then next cycle lane0 id 1 (0x40400000) plus lane1 id 3 (0x40800000), m_ready = 1 -> m_valid for exactly 1 cycle, m_data slots = {1.0, 3.0, 2.0, 4.0}, m_phase = 0, group_count = 1.
- Backpressure and ping-pong: fill bank 0 then bank 1 with m_ready = 0 -> m_valid held with bank 0 data unchanged. Raise m_ready -> bank 0 and bank 1 are presented on consecutive cycles, group_count = 2.
- Out-of-order completion: complete bank 1 while bank 0 is FILLING -> m_valid stays 0. Then complete bank 0 -> bank 0 is presented first, then bank 1.
- Overflow: with bank 0 FULL and m_ready = 0, write lane0 phase 0 id 1 = 0xDEADBEEF -> overflow_err = 1 and the drained slot 1 keeps its original value.
- Collision: in one cycle, lane0 and lane1 both write phase 1, id 2, with data A and B -> collision_err = 1 and slot 2 = A after the group completes.
- Reset mid-fill: write 2 slots of bank 0, assert rst_n = 0 for 1 cycle, then perform the full basic-group sequence -> exactly one group is output, containing only the post-reset data.
